// File: rtl/test_rom_manual.sv
// 8192 x 16 read-only test-word memory with a registered output (1-cycle latency).
// Low 16 words are a hand-coded mask table; all other words follow a fixed XOR rule.
module test_rom_manual #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    localparam logic [DATA_W-1:0] GEN_MASK = DATA_W'(16'h5A5A);

    // Declaration initialiser gives a defined zero before the first clock edge.
    logic [DATA_W-1:0] r_data_p1 = '0;
    logic [DATA_W-1:0] w_word_p0;

    function automatic logic [DATA_W-1:0] rom_table(input logic [3:0] idx);
        logic [DATA_W-1:0] w;
        w = '0;
        case (idx)
            4'd0:  w = DATA_W'(16'h0000);
            4'd1:  w = DATA_W'(16'h0001);
            4'd2:  w = DATA_W'(16'h0003);
            4'd3:  w = DATA_W'(16'h0007);
            4'd4:  w = DATA_W'(16'h000F);
            4'd5:  w = DATA_W'(16'h001F);
            4'd6:  w = DATA_W'(16'h003F);
            4'd7:  w = DATA_W'(16'h007F);
            4'd8:  w = DATA_W'(16'h00FF);
            4'd9:  w = DATA_W'(16'h01FF);
            4'd10: w = DATA_W'(16'h03FF);
            4'd11: w = DATA_W'(16'h07FF);
            4'd12: w = DATA_W'(16'h0FFF);
            4'd13: w = DATA_W'(16'h1FFF);
            4'd14: w = DATA_W'(16'h3FFF);
            4'd15: w = DATA_W'(16'h7FFF);
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w;
        w = '0;
        if (a[ADDR_W-1:4] == '0) begin
            w = rom_table(a[3:0]);
        end else begin
            w = DATA_W'(a) ^ GEN_MASK;
        end
        return w;
    endfunction

    // Stage p0: address decode
    always_comb begin
        w_word_p0 = rom_word(addr);
    end

    // Stage p1: registered read data, reset wins over the read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_p1 <= '0;
        end else begin
            r_data_p1 <= w_word_p0;
        end
    end

    assign data = r_data_p1;

endmodule

// File: tb/tb_test_rom_manual.sv
// Directed bench for test_rom_manual: reset, sweep, latency, high addresses,
// mid-sweep reset and a random back-to-back run against a reference rule.
module tb_test_rom_manual;

    logic        clk;
    logic        rst;
    logic [12:0] addr;
    logic [15:0] data;

    int checks = 0;
    int errors = 0;

    test_rom_manual #(.ADDR_W(13), .DATA_W(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .data (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_rom(input logic [12:0] a);
        logic [15:0] r;
        if (a < 13'd16) r = 16'((32'd1 << a) - 32'd1);
        else            r = {3'b000, a} ^ 16'h5A5A;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [15:0] sweep_exp [0:20];
    logic [12:0] ra;

    initial begin
        sweep_exp[0]  = 16'h0000; sweep_exp[1]  = 16'h0001; sweep_exp[2]  = 16'h0003;
        sweep_exp[3]  = 16'h0007; sweep_exp[4]  = 16'h000F; sweep_exp[5]  = 16'h001F;
        sweep_exp[6]  = 16'h003F; sweep_exp[7]  = 16'h007F; sweep_exp[8]  = 16'h00FF;
        sweep_exp[9]  = 16'h01FF; sweep_exp[10] = 16'h03FF; sweep_exp[11] = 16'h07FF;
        sweep_exp[12] = 16'h0FFF; sweep_exp[13] = 16'h1FFF; sweep_exp[14] = 16'h3FFF;
        sweep_exp[15] = 16'h7FFF; sweep_exp[16] = 16'h5A4A; sweep_exp[17] = 16'h5A4B;
        sweep_exp[18] = 16'h5A48; sweep_exp[19] = 16'h5A49; sweep_exp[20] = 16'h5A4E;

        rst  = 1'b1;
        addr = 13'd5;
        #1;
        chk("powerup", data, 16'h0000);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset_hold", data, 16'h0000);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_release", data, 16'h001F);

        for (int k = 0; k <= 20; k++) begin
            @(negedge clk); addr = 13'(k);
            @(posedge clk); #1;
            chk($sformatf("sweep_%0d", k), data, sweep_exp[k]);
        end

        @(negedge clk); addr = 13'd3;
        @(posedge clk); #1;
        chk("lat_addr3", data, 16'h0007);
        @(negedge clk); addr = 13'd100;
        #1;
        chk("lat_before_edge", data, 16'h0007);
        @(posedge clk); #1;
        chk("lat_after_edge", data, 16'h5A3E);

        @(negedge clk); addr = 13'd4096;
        @(posedge clk); #1;
        chk("addr_4096", data, 16'h4A5A);
        @(negedge clk); addr = 13'd8191;
        @(posedge clk); #1;
        chk("addr_8191", data, 16'h45A5);
        @(negedge clk); addr = 13'd0;
        @(posedge clk); #1;
        chk("wrap_0", data, 16'h0000);

        for (int a = 30; a <= 40; a++) begin
            @(negedge clk); addr = 13'(a); rst = (a == 35);
            @(posedge clk); #1;
            if (a == 35) chk("midrst_35", data, 16'h0000);
            else if (a == 36) chk("midrst_36", data, 16'h5A7E);
            else chk($sformatf("midrst_%0d", a), data, ref_rom(13'(a)));
        end
        @(negedge clk); rst = 1'b0;

        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            ra   = 13'($urandom_range(8191, 0));
            addr = ra;
            @(posedge clk); #1;
            chk($sformatf("rand_%0d_a%0d", n, ra), data, ref_rom(ra));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/test_rom_manual.md
Name: test_rom_manual

Overview:
- Synchronous read-only memory: 8192 words x 16 bits, contents hand-coded in RTL (constant table plus a fixed generator rule).
- Supplies known test words to downstream RSA datapath benches and blocks.
- Single read port with registered output; no write path.

Parameters:
- ADDR_W, 13, address width; depth is 2^ADDR_W words.
- DATA_W, 16, data word width.
- Only the defaults are required to be supported. The content rules below are written for ADDR_W=13 and DATA_W=16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  ADDR_W  read address; sampled on the rising edge of clk.
- data  output  DATA_W  registered read data.

Behaviour:
- Read timing:
  - data is a register. At every rising clk edge with rst=0: data <= ROM[addr].
  - Latency is exactly 1 cycle. There is no combinational path from addr to data.
  - A new address may be presented every cycle, giving full throughput.
- Reset:
  - At a rising edge with rst=1: data <= 16'h0000. Reset takes precedence over the read.
  - data holds 0 until the first edge with rst=0, which loads ROM[addr].
  - Asserting rst in the middle of an address sweep clears data at the next edge. There is no other state.
- Power-up: data initialises to 16'h0000 so simulation never shows X before the first edge.
- Contents, decoded over the full address space (no out-of-range case):
  - addr 0..15: ROM[k] = (1<<k) - 1, which is 0x0000, 0x0001, 0x0003, 0x0007, 0x000F, 0x001F, 0x003F, 0x007F, 0x00FF, 0x01FF, 0x03FF, 0x07FF, 0x0FFF, 0x1FFF, 0x3FFF, 0x7FFF. Coded as an explicit case table.
  - addr 16..8191: ROM[a] = {3'b000, a} XOR 16'h5A5A.
- Address wrap: addr 8191 followed by addr 0 needs no special handling. data follows the address sequence with 1-cycle delay.
- Unknown or X address bits: output behaviour is undefined. Benches must drive known addresses.
- Implementation:
  - Case statement or function evaluated inside a clocked always block.
  - Inferable as block ROM or LUTs.
  - No latches, no initial-file loading; contents live in RTL only.

Test Plan:
- Reset: rst=1 for 3 cycles with addr=5 -> data=0x0000 throughout. Release rst -> next edge data=0x001F.
- Sequential sweep:
  - Drive addr changing on the falling edge, 0,1,2,...,20.
  - Edges following addr 0..15 -> data = 0x0000, 0x0001, ..., 0x7FFF in order.
  - addr=16 -> 0x5A4A; addr=17 -> 0x5A4B; addr=20 -> 0x5A4E.
- Latency: addr changes from 3 to 100 before edge N -> data=0x0007 before edge N, and data=0x5A3E after edge N.
- High addresses:
  - addr=4096 -> 0x4A5A.
  - addr=8191 -> {3'b000,13'h1FFF}^0x5A5A = 0x45A5.
  - Then addr=0 -> 0x0000 (wrap).
- Mid-sweep reset: sweeping addresses 30..40, assert rst for 1 cycle at addr=35 -> data=0x0000 for that cycle. The next edge loads the current address value, e.g. addr=36 -> 0x5A7E.
- Back-to-back random: 1000 random addresses, one per cycle -> every data sample equals the reference rule applied to the address of the previous cycle.
